// File: rtl/uart_pkg.sv
// Shared UART constants: counter width, oversample ratio, common divisors and
// the baud generator run/off state type.
package uart_pkg;

  localparam int DEF_CNT_W       = 20;
  localparam int DEF_OVS         = 16;
  localparam int DIV_9600_100M   = 650;
  localparam int DIV_115200_100M = 53;
  localparam int FRAC_W          = 4;

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_RUN = 1'b1
  } baud_state_e;

endpackage

// File: rtl/uart_frac_acc.sv
// Fractional divisor accumulator. carry reports whether the oversample period
// currently ending must be stretched by one cycle; the accumulator advances on
// each oversample wrap and clears whenever the generator is off or resynced.
module uart_frac_acc
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              adv,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  // Next accumulator value and its carry-out.
  always_comb begin
    sum = {1'b0, acc} + {1'b0, frac};
  end

  assign carry = sum[FRAC_W];

  // Accumulator register: clear has priority over advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (adv) begin
      acc <= sum[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// Baud-rate tick generator: programmable oversample tick plus bit and mid-bit
// ticks derived from a log2(OVS)-bit phase counter. Divisor writes go to a
// shadow register and take effect only at a period boundary, on resync, or
// while off. Optional build macro UART_BAUD_FRAC_EN adds a 4-bit fractional
// divisor (port i_frac) that stretches selected periods by one cycle.
//
// Handshake: i_div_wr and i_resync are single-cycle strobes sampled on the
// rising clock edge; there is no back-pressure. Every output is a register.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int               CNT_W   = DEF_CNT_W,
  parameter int               OVS     = DEF_OVS,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_9600_100M)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic [CNT_W-1:0]  i_div,
  input  logic              i_div_wr,
`ifdef UART_BAUD_FRAC_EN
  input  logic [FRAC_W-1:0] i_frac,
`endif
  input  logic              i_resync,
  output logic              o_os_tick,
  output logic              o_bit_tick,
  output logic              o_mid_tick,
  output logic [CNT_W-1:0]  o_div
);

  localparam int              PH_W    = $clog2(OVS);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVS / 2 - 1);

  baud_state_e      state_q, state_d;
  logic [CNT_W:0]   os_cnt, os_cnt_d;   // one spare bit for a stretched period
  logic [PH_W-1:0]  phase, phase_d;
  logic [CNT_W-1:0] div_q, div_q_d, div_sh, div_sh_d;
  logic             pend, pend_d;
  logic             os_tick_d, bit_tick_d, mid_tick_d;
  logic             active, wrap, apply, carry;

  // Counting only happens once RUN has been entered and enable is still high;
  // the OFF->RUN edge itself is a start cycle that holds the counters at zero.
  assign active = (state_q == ST_RUN) && i_en;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_sh, frac_q, frac_sh_d;

  assign frac_sh_d = i_div_wr ? i_frac : frac_sh;

  // Fractional shadow/active registers move together with the divisor.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frac_sh <= '0;
      frac_q  <= '0;
    end else begin
      frac_sh <= frac_sh_d;
      if (apply) frac_q <= frac_sh_d;
    end
  end

  uart_frac_acc u_frac_acc (
    .clk   (clk),
    .reset (reset),
    .clr   (!active || i_resync),
    .adv   (active && !i_resync && wrap),
    .frac  (frac_q),
    .carry (carry)
  );
`else
  assign carry = 1'b0;
`endif

  // A period ends at div_q, or one cycle later when the fraction carries.
  assign wrap = (os_cnt == ({1'b0, div_q} + {{CNT_W{1'b0}}, carry}));

  // Next state follows enable directly.
  always_comb begin
    state_d = ST_OFF;
    if (i_en) state_d = ST_RUN;
  end

  // Counter, phase, tick and divisor-reload decisions for the coming edge.
  always_comb begin
    os_cnt_d   = os_cnt;
    phase_d    = phase;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    mid_tick_d = 1'b0;
    div_sh_d   = i_div_wr ? i_div : div_sh;
    pend_d     = pend | i_div_wr;
    apply      = 1'b0;
    if (!active) begin
      os_cnt_d = '0;
      phase_d  = '0;
      apply    = pend_d;
    end else if (i_resync) begin
      os_cnt_d = '0;
      phase_d  = '0;
      apply    = pend_d;
    end else if (wrap) begin
      os_cnt_d   = '0;
      os_tick_d  = 1'b1;
      bit_tick_d = (phase == PH_LAST);
      mid_tick_d = (phase == PH_MID);
      phase_d    = phase + PH_W'(1);
      apply      = pend_d;
    end else begin
      os_cnt_d = os_cnt + (CNT_W + 1)'(1);
    end
    div_q_d = apply ? div_sh_d : div_q;
    if (apply) pend_d = 1'b0;
  end

  // State, counters, divisor and registered tick outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_OFF;
      os_cnt     <= '0;
      phase      <= '0;
      div_q      <= DIV_RST;
      div_sh     <= DIV_RST;
      pend       <= 1'b0;
      o_os_tick  <= 1'b0;
      o_bit_tick <= 1'b0;
      o_mid_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      os_cnt     <= os_cnt_d;
      phase      <= phase_d;
      div_q      <= div_q_d;
      div_sh     <= div_sh_d;
      pend       <= pend_d;
      o_os_tick  <= os_tick_d;
      o_bit_tick <= bit_tick_d;
      o_mid_tick <= mid_tick_d;
    end
  end

  assign o_div = div_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen (default build). An event-level reference model
// schedules the next oversample tick as an absolute edge number and counts
// ticks since the last phase restart; it pushes the expected output vector
// {bit, mid, os, div} for every clock edge into exp_q.
module tb_uart_baud_gen;
  import uart_pkg::*;

  localparam int CNT_W   = 20;
  localparam int OVS     = 16;
  localparam int DIV_DEF = 650;
  localparam int W3      = CNT_W + 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             i_en = 1'b0;
  logic             i_div_wr = 1'b0;
  logic             i_resync = 1'b0;
  logic [CNT_W-1:0] i_div = '0;
  logic             o_os_tick, o_bit_tick, o_mid_tick;
  logic [CNT_W-1:0] o_div;
`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] i_frac = '0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int t = 0;          // steps taken by the driver
  int last_os_t = 0;  // step at which o_os_tick was last seen high

  uart_baud_gen #(.CNT_W(CNT_W), .OVS(OVS), .DIV_RST(20'd650)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_en       (i_en),
    .i_div      (i_div),
    .i_div_wr   (i_div_wr),
`ifdef UART_BAUD_FRAC_EN
    .i_frac     (i_frac),
`endif
    .i_resync   (i_resync),
    .o_os_tick  (o_os_tick),
    .o_bit_tick (o_bit_tick),
    .o_mid_tick (o_mid_tick),
    .o_div      (o_div)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog t=%0d got=timeout exp=finish", t);
    $fatal(1, "watchdog expired");
  end

  // Reference model state.
  int              cyc = 0;
  bit              m_run;
  int              m_next, m_k, m_div, m_sh;
  bit              m_pend;
  int              mv_sh;
  bit              mv_pend, mv_os, mv_mid, mv_bit;
  logic [W3-1:0]   exp_q[$];

  // Reference model: one expected vector per clock edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run  = 1'b0;
      m_div  = DIV_DEF;
      m_sh   = DIV_DEF;
      m_pend = 1'b0;
      m_k    = 0;
      exp_q.delete();
    end else begin
      cyc++;
      mv_sh   = i_div_wr ? int'(i_div) : m_sh;
      mv_pend = m_pend | i_div_wr;
      mv_os   = 1'b0;
      mv_mid  = 1'b0;
      mv_bit  = 1'b0;
      if (!i_en) begin
        m_run = 1'b0;
        if (mv_pend) begin m_div = mv_sh; mv_pend = 1'b0; end
      end else if (!m_run) begin
        m_run = 1'b1;
        if (mv_pend) begin m_div = mv_sh; mv_pend = 1'b0; end
        m_next = cyc + m_div + 1;
        m_k    = 0;
      end else if (i_resync) begin
        if (mv_pend) begin m_div = mv_sh; mv_pend = 1'b0; end
        m_next = cyc + m_div + 1;
        m_k    = 0;
      end else if (cyc == m_next) begin
        m_k++;
        mv_os  = 1'b1;
        mv_mid = (m_k % OVS) == (OVS / 2);
        mv_bit = (m_k % OVS) == 0;
        if (mv_pend) begin m_div = mv_sh; mv_pend = 1'b0; end
        m_next = cyc + m_div + 1;
      end
      m_sh   = mv_sh;
      m_pend = mv_pend;
      exp_q.push_back({mv_bit, mv_mid, mv_os, CNT_W'(m_div)});
    end
  end

  function automatic logic [W3-1:0] dut_vec();
    return {o_bit_tick, o_mid_tick, o_os_tick, o_div};
  endfunction

  // Driver: advance one clock edge and fetch that edge's expected vector.
  task automatic step(output logic [W3-1:0] e);
    @(posedge clk);
    @(negedge clk);
    t++;
    if (o_os_tick) last_os_t = t;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else e = 'x;
  endtask

  task automatic test_reset();
    logic [W3-1:0] e;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (dut_vec() !== {3'b000, 20'd650}) begin
      n_err++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec(), {3'b000, 20'd650});
    end
    reset = 1'b1;
    repeat (3) begin
      step(e);
      n_cmp++;
      if (dut_vec() !== e) begin
        n_err++;
        $display("FAIL reset_idle t=%0d got=%h exp=%h", t, dut_vec(), e);
      end
    end
  endtask

  task automatic test_default_div();
    logic [W3-1:0] e;
    int f_os, f_mid, f_bit;
    f_os = -1; f_mid = -1; f_bit = -1;
    i_en = 1'b1;
    for (int n = 0; n <= 16 * 651 + 2; n++) begin
      step(e);
      n_cmp++;
      if (dut_vec() !== e) begin
        n_err++;
        $display("FAIL default_div t=%0d got=%h exp=%h", t, dut_vec(), e);
      end
      if (o_os_tick  && f_os  < 0) f_os  = n;
      if (o_mid_tick && f_mid < 0) f_mid = n;
      if (o_bit_tick && f_bit < 0) f_bit = n;
    end
    n_cmp++;
    if (f_os != 651) begin n_err++; $display("FAIL default_first_os got=%0d exp=651", f_os); end
    n_cmp++;
    if (f_mid != 8 * 651) begin n_err++; $display("FAIL default_first_mid got=%0d exp=%0d", f_mid, 8 * 651); end
    n_cmp++;
    if (f_bit != 16 * 651) begin n_err++; $display("FAIL default_first_bit got=%0d exp=%0d", f_bit, 16 * 651); end
  endtask

  task automatic test_div_write();
    logic [W3-1:0] e;
    int prev, w;
    int os_t[$];
    int bit_t[$];
    w = $urandom_range(5, 600);
    repeat (w) begin
      step(e);
      n_cmp++;
      if (dut_vec() !== e) begin
        n_err++;
        $display("FAIL div_write_pre t=%0d got=%h exp=%h", t, dut_vec(), e);
      end
    end
    prev = last_os_t;
    i_div = 20'd3; i_div_wr = 1'b1;
    step(e);
    i_div_wr = 1'b0;
    n_cmp++;
    if (dut_vec() !== e) begin
      n_err++;
      $display("FAIL div_write_edge t=%0d got=%h exp=%h", t, dut_vec(), e);
    end
    for (int n = 0; n < 651 + 200; n++) begin
      step(e);
      n_cmp++;
      if (dut_vec() !== e) begin
        n_err++;
        $display("FAIL div_write t=%0d got=%h exp=%h", t, dut_vec(), e);
      end
      if (o_os_tick) os_t.push_back(t);
      if (o_bit_tick) bit_t.push_back(t);
    end
    n_cmp++;
    if (os_t.size() < 3 || os_t[0] - prev != 651 || os_t[1] - os_t[0] != 4 || os_t[2] - os_t[1] != 4) begin
      n_err++;
      $display("FAIL div_write_periods got_first_gap=%0d exp=651 then 4", (os_t.size() > 0) ? os_t[0] - prev : -1);
    end
    n_cmp++;
    if (bit_t.size() < 2 || bit_t[1] - bit_t[0] != 64) begin
      n_err++;
      $display("FAIL div_write_bit_period got=%0d exp=64", (bit_t.size() > 1) ? bit_t[1] - bit_t[0] : -1);
    end
  endtask

  task automatic test_resync();
    logic [W3-1:0] e;
    bit found;
    int d, os_cnt_seen, f_os, mid_idx, bit_idx;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      step(e);
      n_cmp++;
      if (dut_vec() !== e) begin
        n_err++;
        $display("FAIL resync_pre t=%0d got=%h exp=%h", t, dut_vec(), e);
      end
      if (e[CNT_W] && (m_k % OVS) == 11) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL resync_find_phase got=0 exp=1"); end
    d = $urandom_range(0, 2);
    repeat (d) begin
      step(e);
      n_cmp++;
      if (dut_vec() !== e) begin
        n_err++;
        $display("FAIL resync_pre t=%0d got=%h exp=%h", t, dut_vec(), e);
      end
    end
    i_resync = 1'b1;
    step(e);
    i_resync = 1'b0;
    n_cmp++;
    if (dut_vec() !== e) begin
      n_err++;
      $display("FAIL resync_edge t=%0d got=%h exp=%h", t, dut_vec(), e);
    end
    os_cnt_seen = 0; f_os = -1; mid_idx = -1; bit_idx = -1;
    for (int n = 1; n <= 80; n++) begin
      step(e);
      n_cmp++;
      if (dut_vec() !== e) begin
        n_err++;
        $display("FAIL resync t=%0d got=%h exp=%h", t, dut_vec(), e);
      end
      if (o_os_tick) begin
        os_cnt_seen++;
        if (f_os < 0) f_os = n;
        if (o_mid_tick && mid_idx < 0) mid_idx = os_cnt_seen;
        if (o_bit_tick && bit_idx < 0) bit_idx = os_cnt_seen;
      end
    end
    n_cmp++;
    if (f_os != 4) begin n_err++; $display("FAIL resync_first_os got=%0d exp=4", f_os); end
    n_cmp++;
    if (mid_idx != 8) begin n_err++; $display("FAIL resync_first_mid got=%0d exp=8", mid_idx); end
    n_cmp++;
    if (bit_idx != 16) begin n_err++; $display("FAIL resync_first_bit got=%0d exp=16", bit_idx); end
  endtask

  task automatic test_enable_gap();
    logic [W3-1:0] e;
    int ticks_off, f_os, f_bit;
    i_div = 20'd9; i_div_wr = 1'b1;
    step(e);
    i_div_wr = 1'b0;
    repeat (12) begin
      step(e);
      n_cmp++;
      if (dut_vec() !== e) begin
        n_err++;
        $display("FAIL en_gap_pre t=%0d got=%h exp=%h", t, dut_vec(), e);
      end
    end
    i_en = 1'b0;
    ticks_off = 0;
    repeat (20) begin
      step(e);
      n_cmp++;
      if (dut_vec() !== e) begin
        n_err++;
        $display("FAIL en_gap_off t=%0d got=%h exp=%h", t, dut_vec(), e);
      end
      if (o_os_tick || o_mid_tick || o_bit_tick) ticks_off++;
    end
    n_cmp++;
    if (ticks_off != 0) begin n_err++; $display("FAIL en_gap_no_ticks got=%0d exp=0", ticks_off); end
    i_en = 1'b1;
    f_os = -1; f_bit = -1;
    for (int n = 0; n <= 170; n++) begin
      step(e);
      n_cmp++;
      if (dut_vec() !== e) begin
        n_err++;
        $display("FAIL en_gap_on t=%0d got=%h exp=%h", t, dut_vec(), e);
      end
      if (o_os_tick && f_os < 0) f_os = n;
      if (o_bit_tick && f_bit < 0) f_bit = n;
    end
    n_cmp++;
    if (f_os != 10) begin n_err++; $display("FAIL en_gap_first_os got=%0d exp=10", f_os); end
    n_cmp++;
    if (f_bit != 160) begin n_err++; $display("FAIL en_gap_first_bit got=%0d exp=160", f_bit); end
  endtask

  task automatic test_div_zero();
    logic [W3-1:0] e;
    int os_n;
    int bit_t[$];
    i_div = 20'd0; i_div_wr = 1'b1; i_resync = 1'b1;
    step(e);
    i_div_wr = 1'b0; i_resync = 1'b0;
    n_cmp++;
    if (dut_vec() !== e) begin
      n_err++;
      $display("FAIL div0_edge t=%0d got=%h exp=%h", t, dut_vec(), e);
    end
    os_n = 0;
    for (int n = 1; n <= 40; n++) begin
      step(e);
      n_cmp++;
      if (dut_vec() !== e) begin
        n_err++;
        $display("FAIL div0 t=%0d got=%h exp=%h", t, dut_vec(), e);
      end
      if (o_os_tick) os_n++;
      if (o_bit_tick) bit_t.push_back(n);
    end
    n_cmp++;
    if (os_n != 40) begin n_err++; $display("FAIL div0_every_cycle got=%0d exp=40", os_n); end
    n_cmp++;
    if (bit_t.size() < 2 || bit_t[1] - bit_t[0] != 16) begin
      n_err++;
      $display("FAIL div0_bit_period got=%0d exp=16", (bit_t.size() > 1) ? bit_t[1] - bit_t[0] : -1);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec() !== {3'b000, 20'd650}) begin
      n_err++;
      $display("FAIL reset_midrun got=%h exp=%h", dut_vec(), {3'b000, 20'd650});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    repeat (10) begin
      step(e);
      n_cmp++;
      if (dut_vec() !== e) begin
        n_err++;
        $display("FAIL after_reset t=%0d got=%h exp=%h", t, dut_vec(), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W3-1:0] e;
    int os_t[$];
    i_div = 20'd5; i_div_wr = 1'b1; i_resync = 1'b1;
    step(e);
    i_div_wr = 1'b0; i_resync = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (n == 2) begin i_div = 20'd2; i_div_wr = 1'b1; end
      if (n == 3) begin i_div = 20'd7; i_div_wr = 1'b1; end
      step(e);
      i_div_wr = 1'b0;
      n_cmp++;
      if (dut_vec() !== e) begin
        n_err++;
        $display("FAIL back_to_back t=%0d got=%h exp=%h", t, dut_vec(), e);
      end
      if (o_os_tick) os_t.push_back(n);
    end
    n_cmp++;
    if (os_t.size() < 3 || os_t[0] != 6 || os_t[1] != 14 || os_t[2] != 22) begin
      n_err++;
      $display("FAIL last_write_wins got=%0d,%0d exp=6,14", (os_t.size() > 0) ? os_t[0] : -1, (os_t.size() > 1) ? os_t[1] : -1);
    end
  endtask

  task automatic test_random();
    logic [W3-1:0] e;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) i_en = ~i_en;
      i_resync = ($urandom_range(0, 29) == 0);
      i_div_wr = ($urandom_range(0, 24) == 0);
      i_div    = CNT_W'($urandom_range(0, 6));
      step(e);
      n_cmp++;
      if (dut_vec() !== e) begin
        n_err++;
        $display("FAIL random t=%0d got=%h exp=%h", t, dut_vec(), e);
      end
    end
    i_resync = 1'b0;
    i_div_wr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_div_write();
    test_resync();
    test_enable_gap();
    test_div_zero();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
